ami_app_tlb_xlat: RTL and testbench

//  Parametrised per-app TLB and address translator: next generation of the fixed 4-entry AMIAPP_TLB_Entry scheme.

---
 rtl/ami_app_tlb_xlat.sv | 177 +++++++++++++++++
 tb/tb_ami_app_tlb_xlat.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ami_app_tlb_xlat.sv
// Per-app TLB: translates app virtual addresses over NUM_ENTRIES ranges and checks permissions.
// Latency 1 cycle; in_ready follows the output register, and drops outside ENABLED.
module ami_app_tlb_xlat #(
    parameter int NUM_ENTRIES = 4,
    parameter int ADDR_WIDTH  = 64,
    parameter int PAYLOAD_W   = 582,
    parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            ctrl_cmd,
    input  logic                  prog_valid,
    input  logic [IDX_W-1:0]      prog_idx,
    input  logic [1:0]            prog_field,
    input  logic [ADDR_WIDTH-1:0] prog_data,
    output logic [1:0]            tlb_state,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_isWrite,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_isWrite,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [PAYLOAD_W-1:0]  out_payload,
    output logic                  fault_valid,
    output logic [1:0]            fault_cause,
    output logic [ADDR_WIDTH-1:0] fault_addr,
    output logic [31:0]           fault_count
);

    typedef enum logic [1:0] {
        ST_DISABLED    = 2'd0,
        ST_DRAINING    = 2'd1,
        ST_PROGRAMMING = 2'd2,
        ST_ENABLED     = 2'd3
    } state_t;

    localparam logic [1:0] CMD_PROG = 2'd1;
    localparam logic [1:0] CMD_EN   = 2'd2;
    localparam logic [1:0] CMD_DIS  = 2'd3;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_MISS  = 2'd1;
    localparam logic [1:0] CAUSE_PERM  = 2'd2;
    localparam logic [1:0] CAUSE_NOMEM = 2'd3;

    state_t state;
    logic   drain_to_prog;

    logic [ADDR_WIDTH-1:0] va_start [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] va_end   [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] pa       [NUM_ENTRIES];
    logic [3:0]            flags    [NUM_ENTRIES];   // {valid, in_memory, readable, writable}

    logic                  hit;
    logic [ADDR_WIDTH-1:0] hit_va_start;
    logic [ADDR_WIDTH-1:0] hit_pa;
    logic [3:0]            hit_flags;
    logic [1:0]            cause;
    logic [ADDR_WIDTH-1:0] xlat_addr;
    logic                  accept;

    assign tlb_state = state;
    assign in_ready  = (state == ST_ENABLED) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // Scan from the top so the lowest-index hit overwrites any higher one.
    always_comb begin
        hit          = 1'b0;
        hit_va_start = '0;
        hit_pa       = '0;
        hit_flags    = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (flags[i][3] && (in_addr >= va_start[i]) && (in_addr <= va_end[i])) begin
                hit          = 1'b1;
                hit_va_start = va_start[i];
                hit_pa       = pa[i];
                hit_flags    = flags[i];
            end
        end
    end

    always_comb begin
        cause = CAUSE_NONE;
        if (!hit)
            cause = CAUSE_MISS;
        else if (!hit_flags[2])
            cause = CAUSE_NOMEM;
        else if (in_isWrite ? !hit_flags[0] : !hit_flags[1])
            cause = CAUSE_PERM;
    end

    assign xlat_addr = hit_pa + (in_addr - hit_va_start);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_DISABLED;
            drain_to_prog <= 1'b0;
        end else begin
            case (state)
                ST_DISABLED: begin
                    if (ctrl_cmd == CMD_PROG)
                        state <= ST_PROGRAMMING;
                    else if (ctrl_cmd == CMD_EN)
                        state <= ST_ENABLED;
                end
                ST_ENABLED: begin
                    if (ctrl_cmd == CMD_PROG || ctrl_cmd == CMD_DIS) begin
                        state         <= ST_DRAINING;
                        drain_to_prog <= (ctrl_cmd == CMD_PROG);
                    end
                end
                // A request accepted alongside the command shows up in out_valid here.
                ST_DRAINING: begin
                    if (!out_valid)
                        state <= drain_to_prog ? ST_PROGRAMMING : ST_DISABLED;
                end
                ST_PROGRAMMING: begin
                    if (ctrl_cmd == CMD_EN)
                        state <= ST_ENABLED;
                    else if (ctrl_cmd == CMD_DIS)
                        state <= ST_DISABLED;
                end
                default: state <= ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                flags[i] <= 4'h0;
        end else if (state == ST_PROGRAMMING && prog_valid) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (prog_idx == IDX_W'(i)) begin
                    case (prog_field)
                        2'd0:    va_start[i] <= prog_data;
                        2'd1:    va_end[i]   <= prog_data;
                        2'd2:    pa[i]       <= prog_data;
                        default: flags[i]    <= prog_data[3:0];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            fault_valid <= 1'b0;
            fault_count <= 32'd0;
        end else begin
            fault_valid <= accept && (cause != CAUSE_NONE);
            if (accept && cause != CAUSE_NONE && fault_count != 32'hFFFF_FFFF)
                fault_count <= fault_count + 32'd1;
            if (accept && cause == CAUSE_NONE)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && cause == CAUSE_NONE) begin
            out_isWrite <= in_isWrite;
            out_addr    <= xlat_addr;
            out_payload <= in_payload;
        end
        if (accept && cause != CAUSE_NONE) begin
            fault_cause <= cause;
            fault_addr  <= in_addr;
        end
    end

endmodule

// File: tb/tb_ami_app_tlb_xlat.sv
// Scoreboard bench for ami_app_tlb_xlat: expectations queued at acceptance, checked on output/fault.
module tb_ami_app_tlb_xlat;

    localparam int NE = 4;
    localparam int AW = 64;
    localparam int PW = 582;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    ctrl_cmd;
    logic          prog_valid;
    logic [IW-1:0] prog_idx;
    logic [1:0]    prog_field;
    logic [AW-1:0] prog_data;
    logic [1:0]    tlb_state;
    logic          in_valid;
    logic          in_ready;
    logic          in_isWrite;
    logic [AW-1:0] in_addr;
    logic [PW-1:0] in_payload;
    logic          out_valid;
    logic          out_ready;
    logic          out_isWrite;
    logic [AW-1:0] out_addr;
    logic [PW-1:0] out_payload;
    logic          fault_valid;
    logic [1:0]    fault_cause;
    logic [AW-1:0] fault_addr;
    logic [31:0]   fault_count;

    ami_app_tlb_xlat #(.NUM_ENTRIES(NE), .ADDR_WIDTH(AW), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .ctrl_cmd(ctrl_cmd), .prog_valid(prog_valid),
        .prog_idx(prog_idx), .prog_field(prog_field), .prog_data(prog_data),
        .tlb_state(tlb_state), .in_valid(in_valid), .in_ready(in_ready),
        .in_isWrite(in_isWrite), .in_addr(in_addr), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_isWrite(out_isWrite),
        .out_addr(out_addr), .out_payload(out_payload), .fault_valid(fault_valid),
        .fault_cause(fault_cause), .fault_addr(fault_addr), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            flt;
        logic [1:0]    cause;
        logic [AW-1:0] addr;
        logic          w;
        logic [PW-1:0] pl;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   rand_rdy = 0;
    bit   hold_chk = 0;
    logic [AW-1:0] hold_addr;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] c);
        ctrl_cmd = c;
        tick();
        ctrl_cmd = 2'd0;
    endtask

    task automatic prog(input int idx, input logic [1:0] field, input logic [AW-1:0] data);
        prog_valid = 1'b1;
        prog_idx   = IW'(idx);
        prog_field = field;
        prog_data  = data;
        tick();
        prog_valid = 1'b0;
    endtask

    task automatic prog_entry(input int idx, input logic [AW-1:0] vs, input logic [AW-1:0] ve,
                              input logic [AW-1:0] p, input logic [3:0] fl);
        prog(idx, 2'd0, vs);
        prog(idx, 2'd1, ve);
        prog(idx, 2'd2, p);
        prog(idx, 2'd3, {60'd0, fl});
    endtask

    task automatic set_flags0(input logic [3:0] fl);
        do_cmd(2'd1);
        repeat (2) tick();
        prog(0, 2'd3, {60'd0, fl});
        do_cmd(2'd2);
    endtask

    // Drive one request; the expectation is queued on the edge that accepts it.
    task automatic send(input logic w, input logic [AW-1:0] a, input bit flt,
                        input logic [1:0] cause, input logic [AW-1:0] exp_addr,
                        input logic [1:0] cmd);
        logic [PW-1:0] p;
        exp_t e;
        int n;
        p = '0;
        for (int k = 0; k < 19; k++) p = {p[PW-33:0], 32'($urandom)};
        in_valid   = 1'b1;
        in_isWrite = w;
        in_addr    = a;
        in_payload = p;
        ctrl_cmd   = cmd;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.flt   = flt;
            e.cause = cause;
            e.addr  = flt ? a : exp_addr;
            e.w     = w;
            e.pl    = p;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ctrl_cmd = 2'd0;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_chk = 0;
        end else begin
            if (hold_chk) begin
                check_eq("hold_vld", 64'(out_valid), 64'd1);
                check_eq("hold_addr", out_addr, hold_addr);
            end
            hold_chk  = out_valid && !out_ready;
            hold_addr = out_addr;
            if (fault_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_fault", 64'(fault_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("fault_kind", 64'(fault_valid), 64'(e.flt));
                    if (e.flt) begin
                        check_eq("fault_cause", 64'(fault_cause), 64'(e.cause));
                        check_eq("fault_addr", fault_addr, e.addr);
                    end
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_kind", 64'(out_valid), 64'(!e.flt));
                    if (!e.flt) begin
                        check_eq("out_addr", out_addr, e.addr);
                        check_eq("out_isWrite", 64'(out_isWrite), 64'(e.w));
                        check_eq("out_payload", 64'(out_payload == e.pl), 64'd1);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ctrl_cmd = 2'd0; prog_valid = 1'b0; prog_idx = '0; prog_field = 2'd0;
        prog_data = '0; in_valid = 1'b0; in_isWrite = 1'b0; in_addr = '0; in_payload = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_state", 64'(tlb_state), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_fault_valid", 64'(fault_valid), 64'd0);
        check_eq("rst_fault_count", 64'(fault_count), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);

        // Basic translation, miss fault and pulse width
        do_cmd(2'd1);
        check_eq("st_prog", 64'(tlb_state), 64'd2);
        prog_entry(0, 64'h1000, 64'h1FFF, 64'h8000_0000, 4'hF);
        do_cmd(2'd2);
        check_eq("st_en", 64'(tlb_state), 64'd3);
        send(1'b0, 64'h1040, 0, 2'd0, 64'h8000_0040, 2'd0);
        check_eq("latency_out_vld", 64'(out_valid), 64'd1);
        send(1'b0, 64'h2000, 1, 2'd1, 64'd0, 2'd0);
        check_eq("fault_pulse", 64'(fault_valid), 64'd1);
        check_eq("fault_cnt1", 64'(fault_count), 64'd1);
        tick();
        check_eq("fault_pulse_end", 64'(fault_valid), 64'd0);

        // Permission / residency faults (flags bit3..0 = valid,in_memory,readable,writable)
        set_flags0(4'hE);
        send(1'b1, 64'h1000, 1, 2'd2, 64'd0, 2'd0);
        send(1'b0, 64'h1000, 0, 2'd0, 64'h8000_0000, 2'd0);
        set_flags0(4'hD);
        send(1'b0, 64'h1FFF, 1, 2'd2, 64'd0, 2'd0);
        send(1'b1, 64'h1FFF, 0, 2'd0, 64'h8000_0FFF, 2'd0);
        set_flags0(4'hB);
        send(1'b0, 64'h1800, 1, 2'd3, 64'd0, 2'd0);
        send(1'b1, 64'h1800, 1, 2'd3, 64'd0, 2'd0);
        set_flags0(4'h7);
        send(1'b0, 64'h1040, 1, 2'd1, 64'd0, 2'd0);
        check_eq("fault_cnt6", 64'(fault_count), 64'd6);

        // Overlap priority and inclusive bounds
        do_cmd(2'd1);
        repeat (2) tick();
        check_eq("st_prog2", 64'(tlb_state), 64'd2);
        prog_entry(0, 64'h0, 64'hFFFF, 64'h100, 4'hF);
        prog_entry(1, 64'h0, 64'h1FFFF, 64'h200, 4'hF);
        do_cmd(2'd2);
        send(1'b0, 64'h10, 0, 2'd0, 64'h110, 2'd0);
        send(1'b1, 64'hFFFF, 0, 2'd0, 64'h100FF, 2'd0);
        send(1'b0, 64'h10000, 0, 2'd0, 64'h10200, 2'd0);
        send(1'b0, 64'h20000, 1, 2'd1, 64'd0, 2'd0);

        // Back-to-back traffic against random downstream stalls
        rand_rdy = 1;
        for (int i = 0; i < 16; i++) begin
            logic [AW-1:0] a;
            a = 64'($urandom_range(0, 32'hFFFF));
            send(1'($urandom_range(0, 1)), a, 0, 2'd0, a + 64'h100, 2'd0);
        end
        rand_rdy = 0;
        tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Drain: stalled output holds DRAINING until it leaves
        out_ready = 1'b0;
        send(1'b0, 64'h1040, 0, 2'd0, 64'h1140, 2'd0);
        do_cmd(2'd1);
        check_eq("st_draining", 64'(tlb_state), 64'd1);
        check_eq("drain_in_ready", 64'(in_ready), 64'd0);
        tick();
        check_eq("drain_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        check_eq("drain_out_gone", 64'(out_valid), 64'd0);
        check_eq("st_still_drain", 64'(tlb_state), 64'd1);
        tick();
        check_eq("st_drained_prog", 64'(tlb_state), 64'd2);

        // Programming ignored while enabled
        do_cmd(2'd2);
        prog(0, 2'd2, 64'h999);
        send(1'b0, 64'h10, 0, 2'd0, 64'h110, 2'd0);

        // Saturating fault counter
        force dut.fault_count = 32'hFFFF_FFFF;
        send(1'b0, 64'h30000, 1, 2'd1, 64'd0, 2'd0);
        release dut.fault_count;
        tick();
        send(1'b0, 64'h30000, 1, 2'd1, 64'd0, 2'd0);
        check_eq("fault_cnt_sat", 64'(fault_count), 64'hFFFF_FFFF);

        // Disable command in the same cycle as an accepted request
        send(1'b0, 64'h20, 0, 2'd0, 64'h120, 2'd3);
        check_eq("st_cmd_with_req", 64'(tlb_state), 64'd1);
        repeat (2) tick();
        check_eq("st_disabled", 64'(tlb_state), 64'd0);

        // Reset mid-operation drops the held output and all entries
        do_cmd(2'd2);
        out_ready = 1'b0;
        send(1'b0, 64'h10, 0, 2'd0, 64'h110, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_state", 64'(tlb_state), 64'd0);
        check_eq("mid_rst_fault_count", 64'(fault_count), 64'd0);
        out_ready = 1'b1;
        do_cmd(2'd2);
        send(1'b0, 64'h10, 1, 2'd1, 64'd0, 2'd0);
        check_eq("post_rst_cnt", 64'(fault_count), 64'd1);

        repeat (4) tick();
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
